// File: rtl/ex_issue_ctrl_if.sv
// Decode -> issue -> execute bundle: decode uop fields, execute-side registered copies,
// branch resolution, memory back-pressure and controller status.
interface ex_issue_ctrl_if #(
  parameter int UOP_W = 26
);
  logic             dec_valid;
  logic             dec_ready;
  logic [2:0]       dec_rs;
  logic [2:0]       dec_rt;
  logic [2:0]       dec_rd;
  logic             dec_rs_used;
  logic             dec_rt_used;
  logic             dec_rd_wr;
  logic             dec_ldst;
  logic             dec_mul;
  logic             dec_jmp;
  logic             dec_branch;
  logic [4:0]       dec_opcode;
  logic [UOP_W-1:0] dec_uop_cnt;

  logic             mem_stall;
  logic             br_resolve;
  logic             br_mispredict;

  logic             ex_valid;
  logic             ex_ldst_valid;
  logic             ex_jmp;
  logic             ex_branch;
  logic [2:0]       ex_rs;
  logic [2:0]       ex_rt;
  logic [2:0]       ex_rd;
  logic [4:0]       ex_opcode;
  logic [UOP_W-1:0] ex_uop_cnt;

  logic             flush;
  logic [7:0]       busy_vec;
  logic [15:0]      stall_cycles;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_rd, dec_rs_used, dec_rt_used, dec_rd_wr,
           dec_ldst, dec_mul, dec_jmp, dec_branch, dec_opcode, dec_uop_cnt,
           mem_stall, br_resolve, br_mispredict,
    input  dec_ready, ex_valid, ex_ldst_valid, ex_jmp, ex_branch, ex_rs, ex_rt, ex_rd,
           ex_opcode, ex_uop_cnt, flush, busy_vec, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_rd, dec_rs_used, dec_rt_used, dec_rd_wr,
           dec_ldst, dec_mul, dec_jmp, dec_branch, dec_opcode, dec_uop_cnt,
           mem_stall, br_resolve, br_mispredict,
    output dec_ready, ex_valid, ex_ldst_valid, ex_jmp, ex_branch, ex_rs, ex_rt, ex_rd,
           ex_opcode, ex_uop_cnt, flush, busy_vec, stall_cycles
  );
endinterface

// File: rtl/ex_issue_ctrl.sv
// In-order single-issue controller: per-register latency scoreboard, hazard stall,
// one uop/cycle into execute, and branch sequencing (wait for resolve, then resume or flush).
module ex_issue_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int UOP_W    = 26,
  parameter int LD_LAT   = 2,
  parameter int MUL_LAT  = 4
) (
  input logic           clk,
  input logic           rst,
  ex_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, BR_WAIT, FLUSH} state_e;

  state_e           state;
  logic [2:0]       cnt [NUM_REGS];
  logic [2:0]       lat;
  logic             hazard;
  logic             issue;
  logic [UOP_W-1:0] uop_q;

  assign lat = bus.dec_mul  ? 3'(MUL_LAT) :
               bus.dec_ldst ? 3'(LD_LAT)  : 3'd1;

  // A WAW is safe once the older write retires no later than the new one would.
  assign hazard = (bus.dec_rs_used && cnt[bus.dec_rs] != 3'd0) ||
                  (bus.dec_rt_used && cnt[bus.dec_rt] != 3'd0) ||
                  (bus.dec_rd_wr   && cnt[bus.dec_rd] > lat);

  assign bus.dec_ready  = (state == RUN) && !hazard && !bus.mem_stall;
  assign issue          = bus.dec_valid && bus.dec_ready;
  assign bus.ex_uop_cnt = uop_q;

  always_comb begin
    // NOTE: default assignment first, so no path through the loop can infer a latch.
    bus.busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) bus.busy_vec[r] = (cnt[r] != 3'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset like any state.
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= 3'd0;
    end else if (!bus.mem_stall) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (issue && bus.dec_rd_wr && bus.dec_rd == 3'(r)) cnt[r] <= lat;
        else if (cnt[r] != 3'd0)                           cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.stall_cycles <= '0;
    end else if (bus.dec_valid && !bus.dec_ready && bus.stall_cycles != 16'hFFFF) begin
      bus.stall_cycles <= bus.stall_cycles + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= RUN;
      bus.flush         <= 1'b0;
      bus.ex_valid      <= 1'b0;
      bus.ex_ldst_valid <= 1'b0;
      bus.ex_jmp        <= 1'b0;
      bus.ex_branch     <= 1'b0;
      bus.ex_rs         <= '0;
      bus.ex_rt         <= '0;
      bus.ex_rd         <= '0;
      bus.ex_opcode     <= '0;
      uop_q             <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every register samples pre-edge values.
      bus.ex_valid      <= issue;
      bus.ex_ldst_valid <= issue && bus.dec_ldst;
      bus.ex_jmp        <= issue && bus.dec_jmp;
      bus.ex_branch     <= issue && bus.dec_branch;
      bus.flush         <= 1'b0;
      if (issue) begin
        bus.ex_rs     <= bus.dec_rs;
        bus.ex_rt     <= bus.dec_rt;
        bus.ex_rd     <= bus.dec_rd;
        bus.ex_opcode <= bus.dec_opcode;
        uop_q         <= bus.dec_uop_cnt;
      end

      // Flush leaves the scoreboard alone: older ops already in execute still retire.
      case (state)
        RUN:     if (issue && (bus.dec_jmp || bus.dec_branch)) state <= BR_WAIT;
        BR_WAIT: if (bus.br_resolve) begin
                   if (bus.br_mispredict) begin
                     state     <= FLUSH;
                     bus.flush <= 1'b1;
                   end else begin
                     state <= RUN;
                   end
                 end
        FLUSH:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule
